// File: rtl/csa_accum_sequencer.sv
// ----------------------------------------------------------------------------
// csa_accum_sequencer
//
// Purpose:
//   Sums a job of num_ops operands (1..MAX_OPS), each WIDTH bits wide, using a
//   3:2 carry-save adder stage. The running total is kept in redundant form
//   (sum register S, carry register C). One operand is folded in per accepted
//   beat. At the end a single carry-propagate add resolves S+C into the
//   result. The result is then offered on a valid/ready output handshake.
//
// Optional build macro:
//   CSA_EARLY_RESOLVE_EN
//     Defined   : the RESOLVE cycle is skipped. On the last accepted beat the
//                 result is computed directly as (S^C^X) + (maj(S,C,X) << 1).
//                 out_valid rises one cycle after the last-accept edge.
//     Undefined : four-state flow IDLE -> ACCUM -> RESOLVE -> DONE, giving a
//                 latency of two cycles.
//   Both builds produce identical results.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous active-high reset
//   start      in   1      job request, sampled only in IDLE
//   num_ops    in   CNT_W  operand count, sampled with start
//   busy       out  1      high in every state except IDLE
//   err        out  1      one-cycle pulse after start is sampled with a bad count
//   in_valid   in   1      operand present
//   in_data    in   WIDTH  operand, zero-extended to ACC_W
//   in_ready   out  1      high only in ACCUM
//   out_valid  out  1      result valid, high only in DONE
//   out_ready  in   1      consumer accepts the result
//   result     out  ACC_W  final sum, held between jobs
// ----------------------------------------------------------------------------
module csa_accum_sequencer #(
  parameter int WIDTH   = 4,
  parameter int MAX_OPS = 8,
  parameter int CNT_W   = 4,
  parameter int ACC_W   = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  output logic             busy,
  output logic             err,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [ACC_W-1:0] s_reg;
  logic [ACC_W-1:0] c_reg;
  logic [ACC_W-1:0] result_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] sum_next;
  logic [ACC_W-1:0] carry_next;
  logic             num_ok;
  logic             accept;
  logic             last_beat;

  assign x_ext = {{(ACC_W-WIDTH){1'b0}}, in_data};

  // Bitwise 3:2 compression. Each majority bit is shifted up one position.
  // The majority of the top bit falls off the end. That bit can never be set,
  // because the true total always fits in ACC_W bits.
  assign carry_next[0] = 1'b0;
  generate
    for (genvar gi = 0; gi < ACC_W; gi++) begin : g_csa
      assign sum_next[gi] = s_reg[gi] ^ c_reg[gi] ^ x_ext[gi];
      if (gi < ACC_W-1) begin : g_carry
        assign carry_next[gi+1] = (s_reg[gi] & c_reg[gi]) |
                                  (s_reg[gi] & x_ext[gi]) |
                                  (c_reg[gi] & x_ext[gi]);
      end
    end
  endgenerate

  assign num_ok    = (num_ops != '0) && (num_ops <= CNT_W'(MAX_OPS));
  assign accept    = (state_reg == ACCUM) && in_valid;
  assign last_beat = accept && (cnt_reg == CNT_W'(1));

  assign busy      = (state_reg != IDLE);
  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == DONE);
  assign err       = err_reg;
  assign result    = result_reg;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start && num_ok) begin
          state_next = ACCUM;
        end
      end
      ACCUM: begin
        if (last_beat) begin
`ifdef CSA_EARLY_RESOLVE_EN
          state_next = DONE;
`else
          state_next = RESOLVE;
`endif
        end
      end
      RESOLVE: begin
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: redundant accumulator, operand counter, result and err pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg      <= '0;
      c_reg      <= '0;
      cnt_reg    <= '0;
      result_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      // err is registered, so it lasts one cycle per sampled bad request.
      err_reg <= (state_reg == IDLE) && start && !num_ok;
      case (state_reg)
        IDLE: begin
          if (start && num_ok) begin
            cnt_reg <= num_ops;
            s_reg   <= '0;
            c_reg   <= '0;
          end
        end
        ACCUM: begin
          if (accept) begin
            s_reg   <= sum_next;
            c_reg   <= carry_next;
            cnt_reg <= cnt_reg - CNT_W'(1);
`ifdef CSA_EARLY_RESOLVE_EN
            // Resolve the post-beat redundant pair in the same cycle.
            if (last_beat) begin
              result_reg <= sum_next + carry_next;
            end
`endif
          end
        end
        RESOLVE: begin
          // Single carry-propagate add. It wraps modulo 2^ACC_W, but the total
          // cannot overflow.
          result_reg <= s_reg + c_reg;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_sequencer.sv
module tb_csa_accum_sequencer;

  localparam int WIDTH   = 4;
  localparam int MAX_OPS = 8;
  localparam int CNT_W   = 4;
  localparam int ACC_W   = 7;
`ifdef CSA_EARLY_RESOLVE_EN
  localparam int EXP_LAT = 1;
`else
  localparam int EXP_LAT = 2;
`endif

  logic             clk;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             busy;
  logic             err;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;

  csa_accum_sequencer #(
    .WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_ops(num_ops), .busy(busy),
    .err(err), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .result(result)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int exp_q[$];
  int acc_cnt = 0;
  int ops[8];
  int prev_res;
  bit prev_valid = 0;
  int e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count every accepted operand beat.
  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) acc_cnt++;
  end

  // Scoreboard monitor: result stays stable while offered; compare on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
    end else if (out_valid) begin
      if (prev_valid) check("result_stable", int'(result), prev_res);
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %0d expected none", result);
        end else begin
          e = exp_q.pop_front();
          check("result", int'(result), e);
        end
        prev_valid = 0;
      end else begin
        prev_valid = 1;
        prev_res   = int'(result);
      end
    end else begin
      prev_valid = 0;
    end
  end

  // Full job: model sum, start, operands with gaps, latency, DONE hold, handshake.
  task automatic run_job(input int n, input int gap, input int hold,
                         input bit probe, input string tag);
    int sum = 0;
    int a0;
    int lat;
    for (int i = 0; i < n; i++) sum += ops[i];
    sum = sum % (1 << ACC_W);
    exp_q.push_back(sum);
    $display("job %s: n=%0d gap=%0d hold=%0d expected=%0d", tag, n, gap, hold, sum);
    start   = 1'b1;
    num_ops = CNT_W'(n);
    tick();
    start   = 1'b0;
    num_ops = '0;
    check({tag, "_busy_after_start"}, int'(busy), 1);
    a0 = acc_cnt;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (gap) tick();
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(ops[i]);
      tick();
      in_valid = 1'b0;
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, EXP_LAT);
    check({tag, "_accepts"}, acc_cnt - a0, n);
    if (probe) begin
      start   = 1'b1;
      num_ops = CNT_W'(3);
    end
    repeat (hold) tick();
    start   = 1'b0;
    num_ops = '0;
    if (hold > 0) check({tag, "_valid_held"}, int'(out_valid), 1);
    check({tag, "_busy_in_done"}, int'(busy), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_dropped"}, int'(out_valid), 0);
    check({tag, "_busy_dropped"}, int'(busy), 0);
    check({tag, "_result_held"}, int'(result), sum);
  endtask

  task automatic bad_start(input int n);
    int pulses = 0;
    int active = 0;
    $display("bad start: num_ops=%0d", n);
    start   = 1'b1;
    num_ops = CNT_W'(n);
    tick();
    start   = 1'b0;
    num_ops = '0;
    repeat (4) begin
      pulses += int'(err);
      active += int'(busy) + int'(in_ready);
      tick();
    end
    check("err_pulse_count", pulses, 1);
    check("err_stays_idle", active, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_ops = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #2;
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(err), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_result", int'(result), 0);
    tick();
    rst = 1'b0;
    tick();

    ops[0] = 1; ops[1] = 2; ops[2] = 3;
    run_job(3, 0, 0, 0, "sum123");

    for (int i = 0; i < 8; i++) ops[i] = 15;
    run_job(8, 0, 0, 0, "all15");

    bad_start(0);
    bad_start(9);

    ops[0] = 5; ops[1] = 0; ops[2] = 7; ops[3] = 9;
    run_job(4, 2, 0, 0, "gaps");

    ops[0] = 1; ops[1] = 2; ops[2] = 3;
    run_job(3, 0, 5, 1, "hold");

    // Reset in the middle of a job: the job is discarded and nothing is expected.
    $display("job reset_mid: n=5 aborted after 2 accepts");
    start = 1'b1; num_ops = CNT_W'(5);
    tick();
    start = 1'b0; num_ops = '0;
    in_valid = 1'b1; in_data = WIDTH'(3);
    tick();
    in_data = WIDTH'(6);
    tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_err", int'(err), 0);
    check("midrst_in_ready", int'(in_ready), 0);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_result", int'(result), 0);
    tick();
    rst = 1'b0;
    tick();
    ops[0] = 4; ops[1] = 4;
    run_job(2, 0, 0, 0, "after_rst");

    for (int j = 0; j < 20; j++) begin
      int n;
      n = int'($urandom_range(1, MAX_OPS));
      for (int i = 0; i < n; i++) ops[i] = int'($urandom_range(0, 15));
      run_job(n, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) bad_start(int'($urandom_range(9, 15)));
    end

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_accum_sequencer.md
Name: csa_accum_sequencer

Overview:
- Sequences a 3:2 carry-save adder stage to sum a stream of NUM operands (1..MAX_OPS) of WIDTH bits each.
- Keeps redundant sum/carry registers (S, C) and folds one operand per accepted beat.
- Resolves S+C with a single carry-propagate add and presents the result over a valid/ready output handshake.
- Sits between an operand source and its consumer as the controller/owner of the CSA datapath.

Parameters:
- WIDTH, 4, operand width in bits.
- MAX_OPS, 8, maximum operands per job.
- CNT_W, 4, width of num_ops and the internal down-counter; must hold MAX_OPS.
- ACC_W, 7, accumulator/result width; must be at least WIDTH+clog2(MAX_OPS), so that MAX_OPS*(2^WIDTH-1) fits without overflow.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  job request; sampled only in IDLE.
- num_ops  input  CNT_W  operand count for the job; sampled with start.
- busy  output  1  high in every state except IDLE.
- err  output  1  one-cycle pulse when start is sampled with a bad num_ops.
- in_valid  input  1  operand present.
- in_data  input  WIDTH  operand, zero-extended to ACC_W.
- in_ready  output  1  high only in ACCUM.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  ACC_W  final sum; holds its value outside DONE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, S=0, C=0, cnt=0, result=0. All outputs low: busy, err, in_ready, out_valid.
- States: IDLE, ACCUM, RESOLVE, DONE.
- IDLE:
  - start=1 with 1<=num_ops<=MAX_OPS: cnt<=num_ops, S<=0, C<=0, go to ACCUM.
  - start=1 with num_ops=0 or num_ops>MAX_OPS: err=1 for exactly one cycle, stay in IDLE.
- ACCUM: in_ready=1. On each beat with in_valid&in_ready, X = zero-extended in_data:
  - S<=S^C^X
  - C<=((S&C)|(S&X)|(C&X))<<1, truncated to ACC_W
  - cnt<=cnt-1
  - With in_valid=0 the state holds and no registers change; gaps are unlimited.
  - When cnt=1 and a beat is accepted, go to RESOLVE.
- RESOLVE: result<=S+C mod 2^ACC_W, go to DONE. Lasts exactly one cycle.
- DONE: out_valid=1, result stable. When out_ready=1, go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises 2 cycles after the edge that accepts the last operand.
- Back-to-back jobs: start is ignored while busy=1. The earliest new start is sampled in the IDLE cycle following DONE.
- Reset mid-job: the job is discarded. No out_valid and no err result from it.
- Arithmetic: no overflow is possible under the ACC_W constraint; no saturation logic.

Optional Feature:
- CSA_EARLY_RESOLVE_EN
- Defined: RESOLVE is removed. On the last accepted beat the block registers result<=(S^C^X)+(maj(S,C,X)<<1) directly and goes straight to DONE. out_valid rises 1 cycle after the last-accept edge.
- Undefined: the 4-state flow above applies, with 2-cycle latency.
- Results are identical in both builds.

Test Plan:
- start, num_ops=3; operands 1,2,3 on consecutive cycles -> result=6; out_valid 2 cycles after last accept (1 cycle with CSA_EARLY_RESOLVE_EN).
- num_ops=8, all operands 15 -> result=120 (0x78); busy high from the cycle after start until the cycle after the DONE handshake.
- num_ops=0, then num_ops=9 -> err pulses 1 cycle each; busy and in_ready stay 0; state stays IDLE.
- num_ops=4, operands 5,0,7,9 with in_valid low for 2 cycles between each -> result=21; no extra accepts during gaps.
- Result 6 reached with out_ready held low for 5 cycles -> out_valid and result=6 held stable; one handshake, then IDLE. A start issued during DONE is ignored.
- num_ops=5; rst asserted after 2 accepts -> all outputs 0 immediately. A new job of 4,4 then yields result=8.
